// File: rtl/renode_apb3_requester_if.sv
// Bundles the command channel, the response channel and the APB3 bus of
// renode_apb3_requester. The master modport is the requester's view; the
// slave modport is the view of whatever drives commands and models the
// completer.
interface renode_apb3_requester_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
) ();

  // command channel
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddressWidth-1:0] cmd_addr;
  logic [DataWidth-1:0]    cmd_wdata;

  // response channel
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_error;
  logic                    rsp_timeout;

  // APB3 bus
  logic [AddressWidth-1:0] paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic [DataWidth-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  paddr, psel, penable, pwrite, pwdata
  );

endinterface

// File: rtl/renode_apb3_requester.sv
// APB3 requester: turns valid/ready commands into APB3 transfers and returns
// each completion on a one-entry response register. A wait-state watchdog
// aborts transfers whose completer never raises pready.
module renode_apb3_requester #(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                           pclk,
  input  logic                           presetn,
  renode_apb3_requester_if.master        bus
);

  // A disabled watchdog still needs a non-zero-width counter.
  localparam int              CntW     = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam int              LastWait = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(LastWait);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
  localparam bit              WdogEn   = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  r_state;
  logic [AddressWidth-1:0] r_paddr;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DataWidth-1:0]    r_pwdata;
  logic                    r_rsp_valid;
  logic [DataWidth-1:0]    r_rsp_rdata;
  logic                    r_rsp_error;
  logic                    r_rsp_timeout;
  logic [CntW-1:0]         r_wait_cnt;

  logic                    w_cmd_ready;
  logic                    w_cmd_fire;
  logic                    w_rsp_fire;
  logic                    w_wdog_hit;

  // A new command is only taken when the response slot is free or being
  // drained on the same edge, so a completion can never overwrite a response.
  assign w_cmd_ready = presetn && (r_state == ST_IDLE) && (!r_rsp_valid || bus.rsp_ready);
  assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
  assign w_rsp_fire  = r_rsp_valid && bus.rsp_ready;
  assign w_wdog_hit  = WdogEn && (r_wait_cnt == CntLast);

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.paddr       = r_paddr;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_error   = r_rsp_error;
  assign bus.rsp_timeout = r_rsp_timeout;

  // Transfer FSM with registered APB outputs, wait watchdog and response slot.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= ST_IDLE;
      r_paddr       <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      // Consumed response; a completion below can never coincide with this.
      if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_paddr   <= bus.cmd_addr;
            r_pwrite  <= bus.cmd_write;
            r_pwdata  <= bus.cmd_wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            // Normal completion; also wins over a same-edge watchdog abort.
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
            r_rsp_error   <= bus.pslverr;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (w_wdog_hit) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (WdogEn || (r_wait_cnt != CntMax)) begin
            r_wait_cnt <= r_wait_cnt + CntW'(1);
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_renode_apb3_requester.sv
// Directed bench for renode_apb3_requester: one DUT with an 8-cycle watchdog
// and one with the watchdog disabled. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_renode_apb3_requester;

  localparam int AW = 20;
  localparam int DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  renode_apb3_requester_if #(.AddressWidth(AW), .DataWidth(DW)) bus  ();
  renode_apb3_requester_if #(.AddressWidth(AW), .DataWidth(DW)) bus0 ();

  renode_apb3_requester #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(8)) dut (
    .pclk(clk), .presetn(rstn), .bus(bus.master)
  );

  renode_apb3_requester #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(0)) dut0 (
    .pclk(clk), .presetn(rstn), .bus(bus0.master)
  );

  // Present one command for a single edge; returns at the falling edge after it.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Walk the transfer, raising pready in ACCESS cycle ready_at (0 = never).
  // n = number of ACCESS cycles seen, or -1 if the transfer never ended.
  task automatic run_access(input int ready_at, output int n);
    int c;
    n = 0;
    c = 0;
    while (bus.psel && c < 2000) begin
      if (bus.penable) begin
        n++;
        bus.pready = (n == ready_at);
      end
      @(negedge clk);
      c++;
    end
    bus.pready = 1'b0;
    if (bus.psel) n = -1;
  endtask

  // Consume any pending response.
  task automatic drain();
    bus.rsp_ready  = 1'b1;
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus0.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int busy;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 20'h0ABCD;
    bus.cmd_wdata = 32'h11223344;
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.cmd_ready});
    end
    n_tests++;
    if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== {AW'(0), DW'(0), DW'(0)}) begin
      n_fail++;
      $display("FAIL reset_data: paddr %h pwdata %h rsp_rdata %h expected all 0", bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    bus.cmd_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready);
    end
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.psel !== 1'b0 || bus.penable !== 1'b0) busy++;
      @(negedge clk);
    end
    n_tests++;
    if (busy !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_bus: got %0d active cycles expected 0", busy);
    end
  endtask

  task automatic test_write();
    int n;
    bus.pready = 1'b0;
    issue(1'b1, 20'h01000, 32'hDEADBEEF);
    n_tests++;
    if ({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 1'b0, 1'b1, 20'h01000, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_setup: psel %b penable %b pwrite %b paddr %h pwdata %h expected 1 0 1 01000 deadbeef",
               bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
    end
    run_access(1, n);
    n_tests++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL write_access_cycles: got %0d expected 1", n);
    end
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout, bus.penable} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL write_rsp: valid %b rdata %h err %b to %b penable %b expected 1 00000000 0 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout, bus.penable);
    end
    drain();
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_rsp_consumed: got %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    int n;
    bus.prdata = 32'h12345678;
    issue(1'b0, 20'h00040, 32'h0);
    run_access(4, n);
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL read_wait_cycles: got %0d expected 4", n);
    end
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout} !== {1'b1, 32'h12345678, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL read_wait_rsp: valid %b rdata %h err %b to %b expected 1 12345678 0 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout);
    end
    drain();
  endtask

  task automatic test_slverr();
    int n;
    bus.prdata  = 32'hCAFEF00D;
    bus.pslverr = 1'b1;
    issue(1'b0, 20'h00080, 32'h0);
    run_access(1, n);
    bus.pslverr = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout} !== {1'b1, 32'hCAFEF00D, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL slverr_rsp: valid %b rdata %h err %b to %b expected 1 cafef00d 1 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout);
    end
    drain();
  endtask

  task automatic test_timeout();
    int n;
    bus.prdata = 32'hA5A5A5A5;
    issue(1'b0, 20'h00100, 32'h0);
    run_access(0, n);
    n_tests++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d expected 8", n);
    end
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_rsp: valid %b rdata %h err %b to %b expected 1 00000000 1 1",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout);
    end
    drain();
    issue(1'b1, 20'h00104, 32'h00000001);
    run_access(1, n);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 3'b100 || n !== 1) begin
      n_fail++;
      $display("FAIL timeout_recover: valid %b err %b to %b cycles %0d expected 1 0 0 1",
               bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, n);
    end
    drain();
    // pready arriving in the last allowed ACCESS cycle completes normally
    bus.prdata = 32'h0BADCAFE;
    issue(1'b0, 20'h00108, 32'h0);
    run_access(8, n);
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout} !== {1'b1, 32'h0BADCAFE, 1'b0, 1'b0} || n !== 8) begin
      n_fail++;
      $display("FAIL timeout_ready_wins: valid %b rdata %h err %b to %b cycles %0d expected 1 0badcafe 0 0 8",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout, n);
    end
    drain();
  endtask

  task automatic test_no_watchdog();
    int held;
    bus0.cmd_valid = 1'b1;
    bus0.cmd_write = 1'b0;
    bus0.cmd_addr  = 20'h00200;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    @(negedge clk);
    held = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus0.psel && bus0.penable && !bus0.rsp_valid) held++;
    end
    n_tests++;
    if (held !== 1000) begin
      n_fail++;
      $display("FAIL nowdog_held: got %0d access cycles expected 1000", held);
    end
    bus0.prdata = 32'h55AA55AA;
    bus0.pready = 1'b1;
    @(negedge clk);
    bus0.pready = 1'b0;
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, bus0.rsp_timeout} !== {1'b1, 32'h55AA55AA, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL nowdog_rsp: valid %b rdata %h err %b to %b expected 1 55aa55aa 0 0",
               bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_error, bus0.rsp_timeout);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    issue(1'b1, 20'h01234, 32'h0000AAAA);
    run_access(1, n);
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_blocked: rsp_valid %b cmd_ready %b expected 1 0", bus.rsp_valid, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 20'h02000;
    bus.cmd_wdata = 32'h0000BBBB;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.psel !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b expected 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    n_tests++;
    if ({bus.psel, bus.penable, bus.paddr, bus.pwdata, bus.rsp_valid} !== {1'b1, 1'b0, 20'h02000, 32'h0000BBBB, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_second_issue: psel %b penable %b paddr %h pwdata %h rsp_valid %b expected 1 0 02000 0000bbbb 0",
               bus.psel, bus.penable, bus.paddr, bus.pwdata, bus.rsp_valid);
    end
    run_access(1, n);
    drain();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 20'h00300, 32'h0);
    @(negedge clk);
    n_tests++;
    if (bus.penable !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_access: penable %b expected 1", bus.penable);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: psel %b penable %b expected 0 0", bus.psel, bus.penable);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.rsp_valid, bus.psel, bus.cmd_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_after: rsp_valid %b psel %b cmd_ready %b expected 0 0 1",
               bus.rsp_valid, bus.psel, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int setups;
    int rsps;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 20'h03000;
    bus.cmd_wdata = 32'h00000003;
    setups = 0;
    rsps   = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus.psel && !bus.penable) setups++;
      if (bus.rsp_valid) rsps++;
    end
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    n_tests++;
    if (setups !== 3 || rsps !== 3) begin
      n_fail++;
      $display("FAIL b2b_throughput: setups %0d rsps %0d expected 3 3", setups, rsps);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t expected finish", $time);
    $fatal(1, "global timeout");
  end

  // Test sequence.
  initial begin
    bus.cmd_valid  = 1'b0; bus.cmd_write  = 1'b0; bus.cmd_addr  = '0; bus.cmd_wdata  = '0;
    bus.rsp_ready  = 1'b0; bus.prdata     = '0;   bus.pready    = 1'b0; bus.pslverr  = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    bus0.rsp_ready = 1'b0; bus0.prdata    = '0;   bus0.pready   = 1'b0; bus0.pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_no_watchdog();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
